// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared states, default widths and the BIST data pattern.
package ram_bist_pkg;
    typedef enum logic [2:0] {IDLE, WR0, RD0, CHK0, WR1, RD1, CHK1} state_t;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;
    function automatic logic [63:0] pattern(logic [63:0] a, logic [63:0] seed, logic ph);
        return ph ? ~(a ^ seed) : (a ^ seed);
    endfunction
endpackage

// File: rtl/ram_bist_if.sv
// ram_bist_if: write/read port bundle between the BIST controller and the RAM.
interface ram_bist_if import ram_bist_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_w_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_r_addr;
    logic [DATA_W-1:0] mem_dout;
    modport master(output mem_we, mem_w_addr, mem_din, mem_re, mem_r_addr, input mem_dout);
    modport slave(input mem_we, mem_w_addr, mem_din, mem_re, mem_r_addr, output mem_dout);
endinterface

// File: rtl/ram_bist_ctrl_cmp.sv
// ram_bist_cmp: read-data checker with expected-value pipeline, error count and first-fail latch.
module ram_bist_cmp import ram_bist_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              re,
    input  logic [ADDR_W-1:0] r_addr,
    input  logic              ph,
    input  logic [DATA_W-1:0] dout,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              fail_phase,
    output logic [ADDR_W+1:0] err_cnt
);
    logic              vld, ph_d, miss;
    logic [DATA_W-1:0] exp_d;
    logic [ADDR_W-1:0] addr_d;
    assign miss = vld && dout != exp_d;
    // expected word and address trail the read by one cycle so they line up with dout
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            vld        <= 1'b0;
            ph_d       <= 1'b0;
            exp_d      <= '0;
            addr_d     <= '0;
            err_cnt    <= '0;
            fail_addr  <= '0;
            fail_phase <= 1'b0;
        end else begin
            vld    <= re;
            ph_d   <= ph;
            exp_d  <= DATA_W'(pattern(64'(r_addr), 64'(PATTERN), ph));
            addr_d <= r_addr;
            if (clr) begin
                err_cnt    <= '0;
                fail_addr  <= '0;
                fail_phase <= 1'b0;
            end else if (miss) begin
                err_cnt <= &err_cnt ? err_cnt : err_cnt + 1'b1;
                if (err_cnt == '0) begin
                    fail_addr  <= addr_d;
                    fail_phase <= ph_d;
                end
            end
        end
endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: two-phase write/read-verify BIST sequencer for a 1-cycle-read dual-port RAM.
module ram_bist_ctrl import ram_bist_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(8'hA5)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] fail_addr,
    output logic              fail_phase,
    output logic [ADDR_W+1:0] err_cnt,
    ram_bist_if.master        mem
);
    state_t            state, nxt;
    logic [ADDR_W-1:0] cnt, nxt_cnt;
    logic              nxt_we, nxt_re, accept, res_vld;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= nxt_cnt;
        end
    // the counter wraps to 0 on the last address, so it is already reset for the next phase
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? WR0 : IDLE;
            WR0:     nxt = &cnt ? RD0 : WR0;
            RD0:     nxt = &cnt ? CHK0 : RD0;
            CHK0:    nxt = WR1;
            WR1:     nxt = &cnt ? RD1 : WR1;
            RD1:     nxt = &cnt ? CHK1 : RD1;
            default: nxt = IDLE;
        endcase
        nxt_cnt = state inside {WR0, RD0, WR1, RD1} ? cnt + 1'b1 : '0;
        nxt_we  = nxt inside {WR0, WR1};
        nxt_re  = nxt inside {RD0, RD1};
        accept  = state == IDLE && start;
    end
    // RAM-side outputs are registered from the next state so they align with it
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            busy           <= 1'b0;
            done           <= 1'b0;
            res_vld        <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_w_addr <= '0;
            mem.mem_din    <= '0;
            mem.mem_re     <= 1'b0;
            mem.mem_r_addr <= '0;
        end else begin
            busy           <= nxt != IDLE;
            done           <= state == CHK1;
            res_vld        <= accept ? 1'b0 : res_vld | (state == CHK1);
            mem.mem_we     <= nxt_we;
            mem.mem_w_addr <= nxt_we ? nxt_cnt : '0;
            mem.mem_din    <= nxt_we ? DATA_W'(pattern(64'(nxt_cnt), 64'(PATTERN), nxt == WR1)) : '0;
            mem.mem_re     <= nxt_re;
            mem.mem_r_addr <= nxt_re ? nxt_cnt : '0;
        end
    assign pass = res_vld && err_cnt == '0;
    ram_bist_cmp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .PATTERN(PATTERN)) u_cmp (
        .clk        (clk),
        .rst        (rst),
        .clr        (accept),
        .re         (mem.mem_re),
        .r_addr     (mem.mem_r_addr),
        .ph         (state == RD1),
        .dout       (mem.mem_dout),
        .fail_addr  (fail_addr),
        .fail_phase (fail_phase),
        .err_cnt    (err_cnt)
    );
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb_ram_bist_ctrl: random-stimulus bench with a faulty-RAM model and a cycle-indexed reference model.
module tb_ram_bist_ctrl;
    logic       clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic       busy, done, pass, fail_phase;
    logic [3:0] fail_addr;
    logic [5:0] err_cnt;
    int         checks = 0, errors = 0, mode = 0;
    int         m_cyc = 0, m_err = 0, m_fa = 0, m_fp = 0, m_res = 0;
    int         k, ph, a, n, dn, md, ee, efa;
    logic [7:0] ram [16];

    ram_bist_if #(.DATA_W(8), .ADDR_W(4)) bus ();
    ram_bist_ctrl #(.DATA_W(8), .ADDR_W(4), .PATTERN(8'hA5)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_addr(fail_addr), .fail_phase(fail_phase), .err_cnt(err_cnt), .mem(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] e_val(int addr, int phase);
        logic [7:0] v = 8'(addr) ^ 8'hA5;
        return phase != 0 ? ~v : v;
    endfunction

    // read-side fault injection: 1 = bit3 stuck-1 at addr 5, 2 = addr 9 reads 0, 3 = dout stuck 0xFF
    function automatic logic [7:0] fault(logic [7:0] v, int addr);
        return (mode == 1 && addr == 5) ? (v | 8'h08) :
               (mode == 2 && addr == 9) ? 8'h00 : (mode == 3) ? 8'hFF : v;
    endfunction

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_w_addr] <= bus.mem_din;
        if (bus.mem_re) bus.mem_dout <= fault(ram[bus.mem_r_addr], int'(bus.mem_r_addr));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // reference: m_cyc is the cycle index since acceptance (0 idle, 67 done cycle)
    always @(posedge clk or posedge rst)
        if (rst) begin
            m_cyc = 0; m_err = 0; m_fa = 0; m_fp = 0; m_res = 0;
        end else begin
            k = m_cyc;
            if ((k >= 18 && k <= 33) || (k >= 51 && k <= 66)) begin
                ph = k >= 51 ? 1 : 0;
                a  = ph != 0 ? k - 51 : k - 18;
                if (fault(e_val(a, ph), a) != e_val(a, ph)) begin
                    if (m_err == 0) begin m_fa = a; m_fp = ph; end
                    if (m_err < 63) m_err++;
                end
            end
            if (k == 0 || k == 67) begin
                if (start) begin m_cyc = 1; m_err = 0; m_fa = 0; m_fp = 0; m_res = 0; end
                else m_cyc = 0;
            end else m_cyc = k + 1;
            if (m_cyc == 67) m_res = 1;
        end

    always @(negedge clk) begin
        automatic int  c   = m_cyc;
        automatic bit  we  = (c >= 1 && c <= 16) || (c >= 34 && c <= 49);
        automatic bit  re  = (c >= 17 && c <= 32) || (c >= 50 && c <= 65);
        automatic int  wa  = c <= 16 ? c - 1 : c - 34;
        automatic int  ra  = c <= 32 ? c - 17 : c - 50;
        chk("busy", 32'(busy), 32'(c >= 1 && c <= 66));
        chk("done", 32'(done), 32'(c == 67));
        chk("mem_we", 32'(bus.mem_we), 32'(we));
        chk("mem_w_addr", 32'(bus.mem_w_addr), we ? wa : 0);
        chk("mem_din", 32'(bus.mem_din), we ? 32'(e_val(wa, c >= 34 ? 1 : 0)) : 0);
        chk("mem_re", 32'(bus.mem_re), 32'(re));
        chk("mem_r_addr", 32'(bus.mem_r_addr), re ? ra : 0);
        chk("err_cnt", 32'(err_cnt), m_err);
        chk("fail_addr", 32'(fail_addr), m_fa);
        chk("fail_phase", 32'(fail_phase), m_fp);
        chk("pass", 32'(pass), 32'(m_res != 0 && m_err == 0));
    end

    task automatic run(input int fm, input bit noise, input int e_err, input int e_fa);
        mode = fm;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            start = noise && ((n == 10) || (n == 40) || (n >= 2 && n <= 60 && $urandom_range(0, 3) == 0));
            if (n == 6) chk("din_a5_ph0", 32'(bus.mem_din), 32'h A0);
            if (n == 39) chk("din_a5_ph1", 32'(bus.mem_din), 32'h 5F);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("done_cycle", n, 67);
        chk("final_err_cnt", 32'(err_cnt), e_err);
        chk("final_fail_addr", 32'(fail_addr), e_fa);
        chk("final_fail_phase", 32'(fail_phase), 0);
        chk("final_pass", 32'(pass), 32'(e_err == 0));
        @(negedge clk);
        chk("done_single", 32'(done), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_we_re", 32'({bus.mem_we, bus.mem_re}), 0);
        chk("rst_err_pass", 32'({err_cnt, pass}), 0);
        @(negedge clk);
        rst = 1'b0;
        run(0, 1'b0, 0, 0);
        run(1, 1'b0, 1, 5);
        run(2, 1'b0, 2, 9);
        run(3, 1'b0, 32, 0);
        // asynchronous reset in the middle of RD0
        mode = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        chk("pre_rst_re", 32'(bus.mem_re), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_we", 32'(bus.mem_we), 0);
        chk("async_rst_re", 32'(bus.mem_re), 0);
        chk("async_rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (80) begin
            @(negedge clk);
            dn += int'(done);
        end
        chk("no_done_after_rst", dn, 0);
        run(0, 1'b0, 0, 0);
        run(0, 1'b1, 0, 0);
        // start held high restarts immediately after done
        start = 1'b1;
        n = 0;
        while (!done && n < 200) begin @(negedge clk); n++; end
        chk("held_first_done", 32'(done), 1);
        @(negedge clk);
        start = 1'b0;
        chk("held_restart_busy", 32'(busy), 1);
        n = 1;
        while (!done && n < 200) begin @(negedge clk); n++; end
        chk("held_second_done_cycle", n, 67);
        for (int i = 0; i < 4; i++) begin
            md  = $urandom_range(0, 3);
            ee  = md == 1 ? 1 : md == 2 ? 2 : md == 3 ? 32 : 0;
            efa = md == 1 ? 5 : md == 2 ? 9 : 0;
            run(md, 1'($urandom_range(0, 1)), ee, efa);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_bist_ctrl.md
Name: ram_bist_ctrl

Overview:
- Built-in self-test initiator for the team's simple dual-port synchronous RAM (16x8 default, separate write and read ports, 1-cycle registered read).
- Drives the RAM's we/w_addr/din and re/r_addr, consumes its dout, and checks the returned data.
- Runs a two-phase write/read-verify pattern test.
- Sits between the RAM and system test logic; reports pass/fail, first failing address/phase, and an error count.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 4, RAM address width; depth = 2**ADDR_W.
- PATTERN, 8'hA5, DATA_W-bit XOR seed for the data pattern.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  test request, sampled in IDLE only.
- busy  out  1  high while a test is running.
- done  out  1  one-cycle pulse when the test completes.
- pass  out  1  result, valid from done until the next start.
- fail_addr  out  ADDR_W  address of the first miscompare.
- fail_phase  out  1  phase (0/1) of the first miscompare.
- err_cnt  out  ADDR_W+2  total miscompares, saturating.
- mem_we  out  1  RAM write enable.
- mem_w_addr  out  ADDR_W  RAM write address.
- mem_din  out  DATA_W  RAM write data.
- mem_re  out  1  RAM read enable.
- mem_r_addr  out  ADDR_W  RAM read address.
- mem_dout  in  DATA_W  RAM read data, valid the cycle after mem_re.

Behaviour:
- Reset is asynchronous and active-high on rst; clk is the single clock.
- Reset values:
  - state=IDLE.
  - busy, done, mem_we, mem_re = 0.
  - pass=0, fail_addr=0, fail_phase=0, err_cnt=0.
  - mem_w_addr, mem_r_addr, mem_din = 0.
- Pattern: E(a,ph) = ph ? ~(zext(a)^PATTERN) : (zext(a)^PATTERN), where zext extends a to DATA_W bits.
- States: IDLE -> WR0 -> RD0 -> CHK0 -> WR1 -> RD1 -> CHK1 -> IDLE.
- IDLE:
  - On start=1, go to WR0 next cycle.
  - Clear err_cnt, pass, fail_addr, fail_phase; set busy=1.
- WRx:
  - One write per cycle: mem_we=1, mem_w_addr=a, mem_din=E(a,x), for a = 0..depth-1 ascending.
  - Go to RDx after the cycle with a=depth-1.
  - mem_re=0 throughout.
- RDx:
  - One read per cycle: mem_re=1, mem_r_addr=a, a = 0..depth-1; mem_we=0.
  - Register the expected value and address one cycle behind, aligned to mem_dout.
- Compare: in the cycle after each read issue, compare mem_dout with the registered expected value.
  - This covers RDx cycles 1..depth-1 and the CHKx cycle, which is the drain of the last read.
  - CHKx issues no RAM access.
- On miscompare:
  - err_cnt increments, saturating at all-ones.
  - If this is the first miscompare since start, latch fail_addr and fail_phase.
  - The test continues; there is no early abort.
- Latency: start accepted in cycle 0; WR0 occupies cycles 1..16 (depth=16); done pulses in the cycle after CHK1, i.e. 2*(2*depth+1)+1 = 67 cycles after acceptance.
- At done: busy falls in the same cycle; pass=(err_cnt==0) from done onward.
- start while busy is ignored. start held high in IDLE after completion immediately begins a new test.
- When mem_we=0 or mem_re=0, the corresponding address/data outputs are driven to 0.
- All RAM-side outputs are registered; no combinational path from mem_dout to any output except through compare registers.
- rst mid-test: all outputs go to reset values immediately (asynchronously), state=IDLE, and the RAM is left partially written; no done pulse.

Decomposition:
- Shared package: state enum (IDLE, WR0, RD0, CHK0, WR1, RD1, CHK1), default widths, and the pattern function E(a,ph).
- Optional sub-module ram_bist_cmp: registered expected/address pipeline, comparator, saturating err_cnt, and first-fail latch.
- The FSM and address counter stay in the top module.

Test Plan:
- Clean behavioural 16x8 RAM model with 1-cycle registered read, start pulse -> busy for 66 cycles; done pulses at cycle 67; pass=1, err_cnt=0. Write data at addr 5 is 0xA0 in phase 0 and 0x5F in phase 1.
- RAM model with bit 3 stuck-at-1 at addr 5 -> pass=0, fail_addr=5, fail_phase=0, err_cnt=1.
- RAM model whose addr 9 read always returns 0x00 -> expected values 0xAC (ph0) and 0x53 (ph1) both miss; err_cnt=2, fail_addr=9, fail_phase=0.
- Assert rst at cycle 30 (during RD0) -> mem_we/mem_re/busy drop immediately, no done; a subsequent start runs a full clean test with pass=1.
- Pulse start at cycles 10 and 40 while busy -> ignored; exactly one done, at cycle 67.
- Stuck-at data on every address (mem_dout tied to 0xFF) -> err_cnt saturates at 63 over the 32 compares? No: it reaches its true count. Count misses of 0xFF against all E values (expected 32 when no E equals 0xFF). Verify err_cnt=32, fail_addr=0, fail_phase=0.
